// File: rtl/alu_op_issuer.sv
// alu_op_issuer: initiator side of the ALU operand interface.
// Takes one request at a time and drives OPA/OPB/CMD/MODE/CIN/CE/INP_VALID.
// Operands go out together or split into two phases with an idle gap between.
// RES and flags are sampled after a command-dependent latency and returned.
// Ports:
//   CLK, RST                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_opa/opb/cmd/mode/cin request operands and command
//   req_split, req_gap       operand split mode and idle gap length
//   OPA..INP_VALID           ALU-side operand outputs
//   RES, COUT..ERR           ALU result and flags
//   rsp_valid/rsp_ready      response handshake
//   rsp_res/flags/timeout    captured result, {COUT,OFLOW,G,E,L,ERR}, gap timeout
module alu_op_issuer #(
   parameter int DW        = 8,
   parameter int CW        = 4,
   parameter int LAT_NORM  = 2,
   parameter int LAT_MUL   = 3,
   parameter int GAP_LIMIT = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [DW-1:0]   req_opa,
   input  logic [DW-1:0]   req_opb,
   input  logic [CW-1:0]   req_cmd,
   input  logic            req_mode,
   input  logic            req_cin,
   input  logic [1:0]      req_split,
   input  logic [4:0]      req_gap,
   output logic [DW-1:0]   OPA,
   output logic [DW-1:0]   OPB,
   output logic [CW-1:0]   CMD,
   output logic            MODE,
   output logic            CIN,
   output logic            CE,
   output logic [1:0]      INP_VALID,
   input  logic [2*DW-1:0] RES,
   input  logic            COUT,
   input  logic            OFLOW,
   input  logic            G,
   input  logic            E,
   input  logic            L,
   input  logic            ERR,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [2*DW-1:0] rsp_res,
   output logic [5:0]      rsp_flags,
   output logic            rsp_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PH1,
      S_GAP,
      S_PH2,
      S_WAIT,
      S_RESP
   } state_t;

   // WAIT runs LAT-1 cycles so the capture edge lands LAT cycles
   // after the edge that launched the final operand.
   localparam logic [4:0] WAIT_NORM = 5'(LAT_NORM - 1);
   localparam logic [4:0] WAIT_MUL  = 5'(LAT_MUL - 1);

   state_t          state_q, state_d;
   logic [DW-1:0]   opa_q, opa_d;
   logic [DW-1:0]   opb_q, opb_d;
   logic [CW-1:0]   cmd_q, cmd_d;
   logic            mode_q, mode_d;
   logic            cin_q, cin_d;
   logic [1:0]      split_q, split_d;
   logic [4:0]      gap_q, gap_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [2*DW-1:0] res_q, res_d;
   logic [5:0]      flags_q, flags_d;
   logic            tmo_q, tmo_d;
   logic            is_mul;
   logic            split_req;
   logic [4:0]      wait_len;

   assign is_mul   = mode_q && (cmd_q == CW'(9) || cmd_q == CW'(10));
   assign wait_len = is_mul ? WAIT_MUL : WAIT_NORM;
   assign split_req = (req_split == 2'b01) || (req_split == 2'b10);

   always_comb begin
      state_d   = state_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      cmd_d     = cmd_q;
      mode_d    = mode_q;
      cin_d     = cin_q;
      split_d   = split_q;
      gap_d     = gap_q;
      cnt_d     = cnt_q;
      res_d     = res_q;
      flags_d   = flags_q;
      tmo_d     = tmo_q;
      req_ready = 1'b0;
      OPA       = '0;
      OPB       = '0;
      CMD       = '0;
      MODE      = 1'b0;
      CIN       = 1'b0;
      CE        = 1'b0;
      INP_VALID = 2'b00;
      rsp_valid = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // Held low while RST is asserted so reset shows no readiness.
            req_ready = !RST;
            if (req_valid && !RST) begin
               opa_d   = req_opa;
               opb_d   = req_opb;
               cmd_d   = req_cmd;
               mode_d  = req_mode;
               cin_d   = req_cin;
               split_d = split_req ? req_split : 2'b00;
               gap_d   = req_gap;
               tmo_d   = split_req &&
                         ({27'd0, req_gap} >= 32'(GAP_LIMIT));
               state_d = S_PH1;
            end
         end
         S_PH1: begin
            CE   = 1'b1;
            CMD  = cmd_q;
            MODE = mode_q;
            CIN  = cin_q;
            unique case (split_q)
               2'b01: begin
                  INP_VALID = 2'b01;
                  OPA       = opa_q;
               end
               2'b10: begin
                  INP_VALID = 2'b10;
                  OPB       = opb_q;
               end
               default: begin
                  INP_VALID = 2'b11;
                  OPA       = opa_q;
                  OPB       = opb_q;
               end
            endcase
            if (split_q == 2'b00) begin
               cnt_d   = wait_len;
               state_d = S_WAIT;
            end else if (gap_q != 5'd0) begin
               cnt_d   = gap_q;
               state_d = S_GAP;
            end else begin
               state_d = S_PH2;
            end
         end
         S_GAP: begin
            CE   = 1'b1;
            CMD  = cmd_q;
            MODE = mode_q;
            CIN  = cin_q;
            if (cnt_q <= 5'd1) begin
               state_d = S_PH2;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         S_PH2: begin
            CE   = 1'b1;
            CMD  = cmd_q;
            MODE = mode_q;
            CIN  = cin_q;
            if (split_q == 2'b01) begin
               INP_VALID = 2'b10;
               OPB       = opb_q;
            end else begin
               INP_VALID = 2'b01;
               OPA       = opa_q;
            end
            cnt_d   = wait_len;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            CE   = 1'b1;
            CMD  = cmd_q;
            MODE = mode_q;
            CIN  = cin_q;
            if (cnt_q <= 5'd1) begin
               res_d   = RES;
               flags_d = {COUT, OFLOW, G, E, L, ERR};
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign rsp_res     = res_q;
   assign rsp_flags   = flags_q;
   assign rsp_timeout = tmo_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         cmd_q   <= '0;
         mode_q  <= 1'b0;
         cin_q   <= 1'b0;
         split_q <= 2'b00;
         gap_q   <= 5'd0;
         cnt_q   <= 5'd0;
         res_q   <= '0;
         flags_q <= 6'd0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         cmd_q   <= cmd_d;
         mode_q  <= mode_d;
         cin_q   <= cin_d;
         split_q <= split_d;
         gap_q   <= gap_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         flags_q <= flags_d;
         tmo_q   <= tmo_d;
      end
   end

endmodule
